// File: rtl/fwft_stream_reader_if.sv
// Bundle of the FWFT FIFO read port and the outgoing valid/ready stream.
// No storage or latency of its own; it only carries signals.
// Backpressure travels on m_ready (stream) and is turned into fifo_rd_en by the reader.
interface fwft_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  // Reader side: consumes the FIFO, sources the stream.
  modport master (
    input  fifo_dout,
    input  fifo_empty,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid
  );

  // Environment side: owns the FIFO and the stream sink.
  modport slave (
    output fifo_dout,
    output fifo_empty,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid
  );
endinterface

// File: rtl/fwft_stream_reader.sv
// Drains a show-ahead FIFO into a registered valid/ready stream via output + skid register.
// Latency: one cycle from pop to m_data/m_valid when the output register is free.
// Backpressure: m_ready low stops draining; the skid absorbs the in-flight pop, then popping stops at 2 words.
module fwft_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  fwft_stream_reader_if.master bus,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] skid_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  pop;
  logic                  drain;

  // Pop decision uses only registered state and the FIFO flag, so m_ready
  // never reaches fifo_rd_en combinationally; reset forces it low.
  assign pop            = !bus.fifo_empty && (state != TWO) && arst_n;
  assign bus.fifo_rd_en = pop;
  assign drain          = bus.m_valid && bus.m_ready;
  assign occupancy      = state;

  // Next-state and buffer steering: the head word always sits in m_data,
  // the second word (if any) in skid.
  always_comb begin
    state_nxt = state;
    data_nxt  = bus.m_data;
    skid_nxt  = skid;
    case (state)
      EMPTY: begin
        if (pop) begin
          state_nxt = ONE;
          data_nxt  = bus.fifo_dout;
        end
      end
      ONE: begin
        if (pop && drain) begin
          data_nxt = bus.fifo_dout;
        end else if (pop) begin
          state_nxt = TWO;
          skid_nxt  = bus.fifo_dout;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_nxt = ONE;
          data_nxt  = skid;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // State, data registers and transfer counter; m_valid is registered
  // alongside the state so it always equals state != EMPTY.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= EMPTY;
      bus.m_data <= '0;
      skid       <= '0;
      bus.m_valid <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      bus.m_data  <= data_nxt;
      skid        <= skid_nxt;
      bus.m_valid <= (state_nxt != EMPTY);
      if (drain) begin
        xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwft_stream_reader.sv
// Bench for fwft_stream_reader: directed cycle table, randomized drain of 1000
// words against a queue model, and a narrow-counter wrap sequence.
module tb_fwft_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic [1:0]  occupancy;
  logic [15:0] xfer_cnt;
  logic [1:0]  occupancy2;
  logic [3:0]  xfer_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  fwft_stream_reader_if #(.DATA_WIDTH(32)) bus ();
  fwft_stream_reader_if #(.DATA_WIDTH(32)) bus2 ();

  fwft_stream_reader #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .arst_n    (rst_n),
    .bus       (bus),
    .occupancy (occupancy),
    .xfer_cnt  (xfer_cnt)
  );

  fwft_stream_reader #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut2 (
    .clk       (clk),
    .arst_n    (rst2_n),
    .bus       (bus2),
    .occupancy (occupancy2),
    .xfer_cnt  (xfer_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One directed cycle: inputs applied mid-cycle, rd_en checked before the
  // edge, registered outputs checked just after it.
  typedef struct {
    logic        rst_n;
    logic        empty;
    logic [31:0] dout;
    logic        ready;
    logic        exp_rd;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [1:0]  exp_occ;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic [31:0] d, logic rdy, logic xrd,
                              logic xv, logic cd, logic [31:0] xd, logic [1:0] xo,
                              logic [15:0] xc);
    vec_t v;
    v.rst_n = r; v.empty = e; v.dout = d; v.ready = rdy; v.exp_rd = xrd;
    v.exp_valid = xv; v.chk_data = cd; v.exp_data = xd; v.exp_occ = xo; v.exp_cnt = xc;
    return v;
  endfunction

  vec_t vecs[19];

  logic [31:0] src_q[$];
  logic [31:0] mdl_q[$];

  initial begin
    logic        p;
    logic        d;
    logic        stalled;
    logic [31:0] stall_data;
    logic [31:0] head;
    int          out_cnt;
    int          cyc;
    int          pops2;
    int          drains2;

    rst_n = 1'b0;
    rst2_n = 1'b0;
    bus.fifo_empty = 1'b0; bus.fifo_dout = 32'h55; bus.m_ready = 1'b1;
    bus2.fifo_empty = 1'b1; bus2.fifo_dout = '0; bus2.m_ready = 1'b0;

    //            rst emp dout    rdy  rd  v  cd  data    occ cnt
    vecs[0]  = mk(0,  0,  32'h55, 1,   0,  0, 1,  32'h0,  0,  0);
    vecs[1]  = mk(0,  0,  32'h55, 1,   0,  0, 1,  32'h0,  0,  0);
    vecs[2]  = mk(1,  0,  32'hA1, 1,   1,  1, 1,  32'hA1, 1,  0);
    vecs[3]  = mk(1,  0,  32'hA2, 1,   1,  1, 1,  32'hA2, 1,  1);
    vecs[4]  = mk(1,  0,  32'hA3, 1,   1,  1, 1,  32'hA3, 1,  2);
    vecs[5]  = mk(1,  1,  32'h0,  1,   0,  0, 0,  32'h0,  0,  3);
    vecs[6]  = mk(1,  0,  32'hB1, 0,   1,  1, 1,  32'hB1, 1,  3);
    vecs[7]  = mk(1,  0,  32'hB2, 0,   1,  1, 1,  32'hB1, 2,  3);
    vecs[8]  = mk(1,  0,  32'hB3, 0,   0,  1, 1,  32'hB1, 2,  3);
    vecs[9]  = mk(1,  0,  32'hB3, 0,   0,  1, 1,  32'hB1, 2,  3);
    vecs[10] = mk(1,  0,  32'hB3, 1,   0,  1, 1,  32'hB2, 1,  4);
    vecs[11] = mk(1,  0,  32'hB3, 1,   1,  1, 1,  32'hB3, 1,  5);
    vecs[12] = mk(1,  1,  32'h0,  1,   0,  0, 0,  32'h0,  0,  6);
    vecs[13] = mk(1,  1,  32'h0,  1,   0,  0, 0,  32'h0,  0,  6);
    vecs[14] = mk(1,  0,  32'hD1, 0,   1,  1, 1,  32'hD1, 1,  6);
    vecs[15] = mk(1,  0,  32'hD2, 0,   1,  1, 1,  32'hD1, 2,  6);
    vecs[16] = mk(0,  0,  32'hD3, 0,   0,  0, 1,  32'h0,  0,  0);
    vecs[17] = mk(1,  0,  32'hC1, 0,   1,  1, 1,  32'hC1, 1,  0);
    vecs[18] = mk(1,  1,  32'h0,  1,   0,  0, 0,  32'h0,  0,  1);

    // Directed table
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      bus.fifo_empty = vecs[i].empty;
      bus.fifo_dout = vecs[i].dout;
      bus.m_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d rd_en", i), 64'(bus.fifo_rd_en), 64'(vecs[i].exp_rd));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d m_valid", i), 64'(bus.m_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d m_data", i), 64'(bus.m_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      check($sformatf("vec%0d xfer_cnt", i), 64'(xfer_cnt), 64'(vecs[i].exp_cnt));
    end

    // Clean reset before the random run
    @(negedge clk);
    rst_n = 1'b0;
    bus.fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    check("rand reset xfer_cnt", 64'(xfer_cnt), 64'd0);
    check("rand reset occupancy", 64'(occupancy), 64'd0);

    for (int i = 0; i < 1000; i++) src_q.push_back(32'h1000 + i);
    mdl_q.delete();
    out_cnt = 0;
    cyc = 0;
    stalled = 1'b0;
    stall_data = '0;

    // Random run: model is a queue of at most two buffered words
    while (out_cnt < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      rst_n = 1'b1;
      bus.fifo_empty = (src_q.size() == 0) || ($urandom_range(0, 9) < 3);
      head = (src_q.size() != 0) ? src_q[0] : 32'hDEAD_0000 + cyc;
      bus.fifo_dout = head;
      bus.m_ready = $urandom_range(0, 1) == 1;
      #1;
      check("rand rd_en", 64'(bus.fifo_rd_en),
            64'(!bus.fifo_empty && mdl_q.size() < 2));
      p = bus.fifo_rd_en && !bus.fifo_empty;
      d = (mdl_q.size() != 0) && bus.m_ready;
      if (d) begin
        check("rand order", 64'(bus.m_data), 64'(32'h1000 + out_cnt));
        out_cnt++;
      end
      stalled = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      @(posedge clk);
      #1;
      if (d) void'(mdl_q.pop_front());
      if (p) begin
        mdl_q.push_back(head);
        void'(src_q.pop_front());
      end
      check("rand m_valid", 64'(bus.m_valid), 64'(mdl_q.size() != 0));
      check("rand occupancy", 64'(occupancy), 64'(mdl_q.size()));
      if (mdl_q.size() != 0) check("rand m_data", 64'(bus.m_data), 64'(mdl_q[0]));
      if (stalled) check("rand stall stable", 64'(bus.m_data), 64'(stall_data));
    end
    check("rand words delivered", 64'(out_cnt), 64'd1000);
    check("rand xfer_cnt", 64'(xfer_cnt), 64'd1000);
    check("rand drained", 64'(occupancy), 64'd0);

    // Narrow counter wrap: 17 transfers on a 4-bit counter
    @(negedge clk);
    bus.fifo_empty = 1'b1;
    #1;
    check("wrap reset xfer_cnt", 64'(xfer_cnt2), 64'd0);
    check("wrap reset rd_en", 64'(bus2.fifo_rd_en), 64'd0);
    rst2_n = 1'b1;
    pops2 = 0;
    drains2 = 0;
    for (int c = 0; c < 60 && drains2 < 17; c++) begin
      bus2.fifo_empty = (pops2 >= 17);
      bus2.fifo_dout = 32'(pops2);
      bus2.m_ready = 1'b1;
      #1;
      p = bus2.fifo_rd_en;
      d = bus2.m_valid && bus2.m_ready;
      @(posedge clk);
      #1;
      if (p) pops2++;
      if (d) begin
        drains2++;
        if (drains2 == 15) check("wrap at 15", 64'(xfer_cnt2), 64'd15);
        if (drains2 == 16) check("wrap to 0", 64'(xfer_cnt2), 64'd0);
      end
      @(negedge clk);
    end
    check("wrap drains", 64'(drains2), 64'd17);
    check("wrap final xfer_cnt", 64'(xfer_cnt2), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwft_stream_reader.md
FWFT_STREAM_READER -- requirements
Module: fwft_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of FIFO and stream data.
REQ-002 Parameter CNT_WIDTH, default 16: width of the transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 arst_n  input  1  reset; synchronous, active-low.
REQ-005 fifo_dout  input  DATA_WIDTH  show-ahead head word of the upstream FWFT FIFO; valid whenever fifo_empty=0.
REQ-006 fifo_empty  input  1  upstream FWFT FIFO empty flag.
REQ-007 fifo_rd_en  output  1  pop strobe to the upstream FIFO; one pop per cycle asserted.
REQ-008 m_data  output  DATA_WIDTH  stream data, registered.
REQ-009 m_valid  output  1  stream valid, registered.
REQ-010 m_ready  input  1  downstream accept.
REQ-011 occupancy  output  2  words held internally: 0, 1 or 2.
REQ-012 xfer_cnt  output  CNT_WIDTH  count of completed stream transfers.

Function
REQ-013 Block SHALL drain an FWFT FIFO into a valid/ready stream through a 2-entry buffer: output register (m_data) plus skid register.
REQ-014 State machine SHALL have states EMPTY (occupancy 0), ONE (1), TWO (2); occupancy SHALL equal the state encoding.
REQ-015 pop = fifo_rd_en; drain = m_valid && m_ready.
REQ-016 fifo_rd_en SHALL be combinational from registered state and fifo_empty only: fifo_rd_en = !fifo_empty && state!=TWO && arst_n; no combinational path from m_ready to fifo_rd_en.
REQ-017 EMPTY: pop -> ONE, m_data<=fifo_dout; else stay.
REQ-018 ONE: pop&&drain -> ONE, m_data<=fifo_dout; pop&&!drain -> TWO, skid<=fifo_dout; !pop&&drain -> EMPTY; else stay, m_data held.
REQ-019 TWO: drain -> ONE, m_data<=skid; else stay, m_data and skid held; no pop in TWO.
REQ-020 m_valid SHALL be 1 exactly when state!=EMPTY.
REQ-021 Latency: word presented at fifo_dout with fifo_empty=0 in cycle N SHALL appear on m_data with m_valid=1 in cycle N+1 when state was EMPTY or draining ONE.
REQ-022 While m_valid=1 and m_ready=0, m_data SHALL remain stable.
REQ-023 Words SHALL leave in FIFO pop order; no loss, no duplication.
REQ-024 Sustained throughput SHALL be one word per cycle when fifo_empty=0 and m_ready=1 continuously.
REQ-025 m_ready asserted while m_valid=0 SHALL have no effect.
REQ-026 xfer_cnt SHALL increment by 1 on each drain, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-027 fifo_empty rising in the same cycle as drain in ONE SHALL yield EMPTY next cycle, m_valid=0.

Reset
REQ-028 arst_n=0 at a clock edge SHALL set state EMPTY, m_valid=0, m_data=0, skid=0, occupancy=0, xfer_cnt=0.
REQ-029 fifo_rd_en SHALL be 0 in every cycle arst_n=0, regardless of fifo_empty.
REQ-030 Reset mid-operation SHALL discard buffered words; no pop issued during reset; normal operation resumes the first cycle after arst_n=1.

Verification
REQ-031 Reset held with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0, occupancy=0, xfer_cnt=0.
REQ-032 FIFO preloaded 0xA1,0xA2,0xA3, m_ready=1 -> pops on 3 consecutive cycles, m_data 0xA1,0xA2,0xA3 on consecutive cycles starting one cycle after first pop, xfer_cnt=3.
REQ-033 FIFO holds 0xB1,0xB2,0xB3, m_ready=0 -> exactly 2 pops, occupancy=2, fifo_rd_en=0, m_data=0xB1 stable; then m_ready=1 -> 0xB1,0xB2,0xB3 in order, occupancy returns to 0.
REQ-034 Random m_ready (50%) and random fifo_empty over 1000 words with incrementing data -> output sequence equals input sequence, m_data stable during every stall, xfer_cnt=1000.
REQ-035 CNT_WIDTH=4, 17 transfers -> xfer_cnt wraps 15->0 and reads 1.
REQ-036 arst_n pulsed low while occupancy=2 -> next cycle occupancy=0, m_valid=0, xfer_cnt=0; subsequent word 0xC1 delivered normally one cycle after pop.
